// File: rtl/ime_bist_pkg.sv
// Shared constants, state/command/status encodings and vector tables for the
// IME pipeline built-in self-test engine.
package ime_bist_pkg;

    localparam int W_P         = 16;
    localparam int W_ACC       = 32;
    localparam int VEC_LEN     = 64;
    localparam int TIMEOUT_CYC = 4096;
    localparam int N_VEC       = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRIVE     = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_DONE_PASS = 3'd3,
        S_DONE_FAIL = 3'd4
    } bist_state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_PASS = 2'b10;
    localparam logic [1:0] ST_FAIL = 2'b11;

    localparam logic [W_P-1:0] LFSR_POLY = 16'hB400;

    // Seeds must be nonzero or the LFSR locks up at zero.
    localparam logic [W_P-1:0] VEC_SEED [N_VEC] = '{
        16'hACE1, 16'h1D0F, 16'h0001, 16'hBEEF,
        16'h5A5A, 16'hFFFF, 16'h8000, 16'h3C96
    };

    // Golden results include values near both signed extremes so the
    // widened comparator is exercised.
    localparam logic [W_ACC-1:0] VEC_GOLD [N_VEC] = '{
        32'h0001_2345, 32'hFFFF_FF00, 32'h7FFF_FFFE, 32'h8000_0001,
        32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00FF
    };

    // One right-shifting Galois step.
    function automatic logic [W_P-1:0] lfsr_step(input logic [W_P-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/ime_bist_lfsr.sv
// Galois LFSR stimulus generator; holds its value unless loaded or advanced.
module ime_bist_lfsr
    import ime_bist_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           advance,
    input  logic [W_P-1:0] seed,
    output logic [W_P-1:0] value
);

    // Load takes priority over advance; zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/ime_bist_engine.sv
// BIST engine: drives an LFSR stimulus frame into the IME pipeline and checks
// the single result word against a golden value within a tolerance.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_IDLE      | no test in progress, status idle
//   S_DRIVE     | presenting stimulus beats to the pipeline
//   S_WAIT_RESP | frame sent, waiting for the pipeline result
//   S_DONE_PASS | result within tolerance, status held until start/clear
//   S_DONE_FAIL | result out of tolerance or timeout, status held
module ime_bist_engine
    import ime_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       bist_cmd,
    input  logic [2:0]       vect_sel,
    input  logic [7:0]       bist_tol,
    output logic             bist_active,
    output logic             stim_valid,
    input  logic             stim_ready,
    output logic [W_P-1:0]   stim_data,
    output logic             stim_last,
    input  logic             resp_valid,
    input  logic [W_ACC-1:0] resp_data,
    output logic [1:0]       bist_status,
    output logic             timeout_err
);

    localparam int BEAT_W = $clog2(VEC_LEN);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC);
    localparam int DW     = W_ACC + 1;

    bist_state_t       state;
    logic [2:0]        sel_q;
    logic [7:0]        tol_q;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              idle_or_done;
    logic              running;
    logic              start_ok;
    logic              abort_ok;
    logic              fire;
    logic              resp_hit;
    logic              tmo_hit;
    logic              clear_ok;
    logic              within_tol;
    logic [W_ACC-1:0]  gold;
    logic signed [DW-1:0] diff;
    logic [DW-1:0]     mag;

    // Event decode and tolerance comparator.
    always_comb begin
        idle_or_done = (state == S_IDLE) || (state == S_DONE_PASS) || (state == S_DONE_FAIL);
        running      = (state == S_DRIVE) || (state == S_WAIT_RESP);
        start_ok     = idle_or_done && (bist_cmd == CMD_START);
        abort_ok     = running && (bist_cmd == CMD_ABORT);
        clear_ok     = ((state == S_DONE_PASS) || (state == S_DONE_FAIL)) && (bist_cmd == CMD_CLEAR);
        fire         = (state == S_DRIVE) && stim_valid && stim_ready;
        resp_hit     = (state == S_WAIT_RESP) && resp_valid;
        tmo_hit      = running && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
        gold         = VEC_GOLD[sel_q];
        // Sign-extend both operands one bit so the difference cannot overflow.
        diff         = $signed({resp_data[W_ACC-1], resp_data}) - $signed({gold[W_ACC-1], gold});
        mag          = diff[DW-1] ? -diff : diff;
        within_tol   = mag <= DW'(tol_q);
    end

    ime_bist_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (start_ok),
        .advance (fire && !abort_ok),
        .seed    (VEC_SEED[vect_sel]),
        .value   (stim_data)
    );

    // FSM, counters and registered outputs; priority abort > response > timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sel_q       <= '0;
            tol_q       <= '0;
            beat_cnt    <= '0;
            tmo_cnt     <= '0;
            bist_active <= 1'b0;
            stim_valid  <= 1'b0;
            stim_last   <= 1'b0;
            bist_status <= ST_IDLE;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (start_ok) begin
                state       <= S_DRIVE;
                sel_q       <= vect_sel;
                tol_q       <= bist_tol;
                beat_cnt    <= '0;
                tmo_cnt     <= '0;
                stim_valid  <= 1'b1;
                stim_last   <= 1'b0;
                bist_active <= 1'b1;
                bist_status <= ST_RUN;
            end else if (abort_ok) begin
                state       <= S_IDLE;
                stim_valid  <= 1'b0;
                stim_last   <= 1'b0;
                bist_active <= 1'b0;
                bist_status <= ST_IDLE;
            end else if (resp_hit) begin
                state       <= within_tol ? S_DONE_PASS : S_DONE_FAIL;
                bist_active <= 1'b0;
                bist_status <= within_tol ? ST_PASS : ST_FAIL;
            end else if (tmo_hit) begin
                state       <= S_DONE_FAIL;
                stim_valid  <= 1'b0;
                stim_last   <= 1'b0;
                bist_active <= 1'b0;
                bist_status <= ST_FAIL;
                timeout_err <= 1'b1;
            end else if (running) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (fire) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (stim_last) begin
                        state      <= S_WAIT_RESP;
                        stim_valid <= 1'b0;
                        stim_last  <= 1'b0;
                    end else if (beat_cnt == BEAT_W'(VEC_LEN - 2)) begin
                        stim_last <= 1'b1;
                    end
                end
            end else if (clear_ok) begin
                state       <= S_IDLE;
                bist_status <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ime_bist_engine.sv
// Scoreboard bench for ime_bist_engine: expected beats and final statuses are
// queued by the stimulus side and popped by an independent monitor.
module tb_ime_bist_engine;
    import ime_bist_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       bist_cmd;
    logic [2:0]       vect_sel;
    logic [7:0]       bist_tol;
    logic             bist_active;
    logic             stim_valid;
    logic             stim_ready;
    logic [W_P-1:0]   stim_data;
    logic             stim_last;
    logic             resp_valid;
    logic [W_ACC-1:0] resp_data;
    logic [1:0]       bist_status;
    logic             timeout_err;

    ime_bist_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bist_cmd    (bist_cmd),
        .vect_sel    (vect_sel),
        .bist_tol    (bist_tol),
        .bist_active (bist_active),
        .stim_valid  (stim_valid),
        .stim_ready  (stim_ready),
        .stim_data   (stim_data),
        .stim_last   (stim_last),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .bist_status (bist_status),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic [W_P:0] beat_q [$];   // {last, data}
    logic [1:0]   res_q  [$];
    int           accepted   = 0;
    int           tmo_pulses = 0;
    bit           stall_prev = 1'b0;
    logic [W_P:0] stall_val  = '0;
    logic [1:0]   status_prev = ST_IDLE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference stimulus: the polynomial rule applied with plain arithmetic.
    function automatic logic [W_P-1:0] model_next(input logic [W_P-1:0] s);
        logic [W_P-1:0] poly;
        poly = 16'hB400;
        return (s % 2 == 1) ? ((s / 2) ^ poly) : (s / 2);
    endfunction

    function automatic bit model_pass(input logic [W_ACC-1:0] r, input int sel, input int tol);
        longint d;
        d = longint'($signed(r)) - longint'($signed(VEC_GOLD[sel]));
        if (d < 0) d = -d;
        return d <= longint'(tol);
    endfunction

    // Monitor: scores every accepted beat, stall stability and run outcomes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && stim_valid)
                check("stall_hold", 64'({stim_last, stim_data}), 64'(stall_val));
            if (stim_valid && stim_ready) begin
                accepted++;
                if (beat_q.size() == 0) begin
                    total++;
                    $display("FAIL beat_unexpected: got %0h expected none", stim_data);
                end else begin
                    check("beat", 64'({stim_last, stim_data}), 64'(beat_q.pop_front()));
                end
            end
            stall_prev = stim_valid && !stim_ready;
            stall_val  = {stim_last, stim_data};
            if (timeout_err) tmo_pulses++;
        end else begin
            stall_prev = 1'b0;
        end
        if (status_prev == ST_RUN && bist_status != ST_RUN) begin
            if (res_q.size() == 0) begin
                total++;
                $display("FAIL result_unexpected: got %0h expected none", bist_status);
            end else begin
                check("result_status", 64'(bist_status), 64'(res_q.pop_front()));
            end
        end
        status_prev = bist_status;
    end

    task automatic start(input int sel, input int tol);
        logic [W_P-1:0] s;
        s = VEC_SEED[sel];
        for (int i = 0; i < VEC_LEN; i++) begin
            beat_q.push_back({(i == VEC_LEN - 1), s});
            s = model_next(s);
        end
        accepted = 0;
        bist_cmd = CMD_START;
        vect_sel = 3'(sel);
        bist_tol = 8'(tol);
        cyc();
        bist_cmd = CMD_NONE;
        check("start_status", 64'(bist_status), 64'(ST_RUN));
        check("start_valid", 64'(stim_valid), 64'(1));
        check("start_active", 64'(bist_active), 64'(1));
        check("start_data", 64'(stim_data), 64'(VEC_SEED[sel]));
        check("start_last", 64'(stim_last), 64'(0));
    endtask

    task automatic drain(input int duty, input bit spurious);
        int n;
        n = 0;
        while (stim_valid && n < 3000) begin
            stim_ready = ($urandom_range(0, 99) < duty);
            if (spurious && n == 5) begin
                resp_valid = 1'b1;
                resp_data  = $urandom;
            end else begin
                resp_valid = 1'b0;
            end
            cyc();
            n++;
        end
        resp_valid = 1'b0;
        stim_ready = 1'b1;
        check("frame_done", 64'(stim_valid), 64'(0));
        check("frame_beats", 64'(accepted), 64'(VEC_LEN));
        check("frame_queue", 64'(beat_q.size()), 64'(0));
        check("wait_status", 64'(bist_status), 64'(ST_RUN));
        check("wait_active", 64'(bist_active), 64'(1));
    endtask

    task automatic respond(input logic [W_ACC-1:0] r, input int sel, input int tol, input int delay);
        logic [1:0] exp;
        if (delay > 0) cyc(delay);
        exp = model_pass(r, sel, tol) ? ST_PASS : ST_FAIL;
        res_q.push_back(exp);
        resp_valid = 1'b1;
        resp_data  = r;
        cyc();
        resp_valid = 1'b0;
        check("resp_status", 64'(bist_status), 64'(exp));
        check("resp_active", 64'(bist_active), 64'(0));
        check("resp_no_tmo", 64'(timeout_err), 64'(0));
    endtask

    task automatic clear_status();
        bist_cmd = CMD_CLEAR;
        cyc();
        bist_cmd = CMD_NONE;
        check("clear_status", 64'(bist_status), 64'(ST_IDLE));
    endtask

    initial begin
        int sel;
        int tol;
        int delta;
        logic [W_ACC-1:0] r;

        rst_n      = 1'b0;
        stim_ready = 1'b1;
        bist_cmd   = CMD_START;
        vect_sel   = '0;
        bist_tol   = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        cyc(3);
        check("rst_status", 64'(bist_status), 64'(ST_IDLE));
        check("rst_valid", 64'(stim_valid), 64'(0));
        check("rst_active", 64'(bist_active), 64'(0));
        check("rst_data", 64'(stim_data), 64'(0));
        check("rst_last", 64'(stim_last), 64'(0));
        check("rst_tmo", 64'(timeout_err), 64'(0));
        bist_cmd = CMD_NONE;
        rst_n    = 1'b1;
        cyc(2);
        check("post_rst_status", 64'(bist_status), 64'(ST_IDLE));

        // Pass with tolerance 1, spurious response during the frame.
        start(0, 1);
        drain(100, 1'b1);
        respond(VEC_GOLD[0] + 32'd1, 0, 1, 2);
        bist_cmd = CMD_ABORT;
        cyc();
        bist_cmd = CMD_NONE;
        check("done_abort_ignored", 64'(bist_status), 64'(ST_PASS));
        clear_status();
        clear_status();

        // Fail by tolerance, late response ignored, then restart from DONE_FAIL.
        start(2, 1);
        drain(100, 1'b0);
        respond(VEC_GOLD[2] - 32'd2, 2, 1, 0);
        resp_valid = 1'b1;
        resp_data  = VEC_GOLD[2];
        cyc();
        resp_valid = 1'b0;
        check("late_resp_ignored", 64'(bist_status), 64'(ST_FAIL));
        start(2, 0);
        drain(100, 1'b0);
        respond(VEC_GOLD[2], 2, 0, 3);
        clear_status();

        // Randomised backpressure and responses around the tolerance edge.
        for (int it = 0; it < 6; it++) begin
            sel   = int'($urandom_range(0, 7));
            tol   = int'($urandom_range(0, 255));
            start(sel, tol);
            drain(50, it == 0);
            delta = int'($urandom_range(0, 2 * tol + 6)) - (tol + 3);
            r     = VEC_GOLD[sel] + 32'(delta);
            respond(r, sel, tol, int'($urandom_range(0, 4)));
            clear_status();
        end

        // Timeout: no response ever arrives.
        tmo_pulses = 0;
        start(5, 0);
        res_q.push_back(ST_FAIL);
        cyc(TIMEOUT_CYC - 1);
        check("tmo_before_status", 64'(bist_status), 64'(ST_RUN));
        check("tmo_before_err", 64'(timeout_err), 64'(0));
        check("tmo_frame_beats", 64'(accepted), 64'(VEC_LEN));
        cyc();
        check("tmo_status", 64'(bist_status), 64'(ST_FAIL));
        check("tmo_err", 64'(timeout_err), 64'(1));
        check("tmo_active", 64'(bist_active), 64'(0));
        cyc();
        check("tmo_err_pulse", 64'(timeout_err), 64'(0));
        check("tmo_pulse_count", 64'(tmo_pulses), 64'(1));
        clear_status();

        // Start/clear ignored while running, then abort at beat 20.
        start(3, 0);
        cyc(10);
        bist_cmd = CMD_START;
        vect_sel = 3'd6;
        cyc();
        bist_cmd = CMD_NONE;
        check("run_start_ignored", 64'(bist_status), 64'(ST_RUN));
        bist_cmd = CMD_CLEAR;
        cyc();
        bist_cmd = CMD_NONE;
        check("run_clear_ignored", 64'(bist_status), 64'(ST_RUN));
        cyc(8);
        res_q.push_back(ST_IDLE);
        bist_cmd = CMD_ABORT;
        cyc();
        bist_cmd = CMD_NONE;
        beat_q.delete();
        check("abort_status", 64'(bist_status), 64'(ST_IDLE));
        check("abort_valid", 64'(stim_valid), 64'(0));
        check("abort_active", 64'(bist_active), 64'(0));
        check("abort_no_err", 64'(timeout_err), 64'(0));
        resp_valid = 1'b1;
        resp_data  = VEC_GOLD[3];
        cyc();
        resp_valid = 1'b0;
        check("abort_late_resp", 64'(bist_status), 64'(ST_IDLE));
        check("abort_pulse_count", 64'(tmo_pulses), 64'(1));

        // Reset in the middle of a frame.
        start(4, 0);
        cyc(7);
        res_q.push_back(ST_IDLE);
        rst_n = 1'b0;
        cyc();
        check("midrst_status", 64'(bist_status), 64'(ST_IDLE));
        check("midrst_valid", 64'(stim_valid), 64'(0));
        check("midrst_data", 64'(stim_data), 64'(0));
        check("midrst_active", 64'(bist_active), 64'(0));
        rst_n = 1'b1;
        beat_q.delete();
        cyc(2);

        check("result_queue_empty", 64'(res_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
